// File: rtl/alu_result_uart_tx_pkg.sv
// Shared encodings for the ALU-result UART path (TX now, RX later).
// Optional feature macro: UART_PARITY_EN (even parity bit per frame).
package alu_result_uart_tx_pkg;

    localparam int DEF_CLKS_PER_BIT = 10417;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    localparam int FLAG_CARRY = 0;
    localparam int FLAG_ZERO  = 1;
    localparam int FLAG_SIGN  = 2;

    function automatic logic [7:0] flag_byte(
        input logic sign,
        input logic zero,
        input logic carry
    );
        logic [7:0] f;
        f = '0;
        f[FLAG_SIGN]  = sign;
        f[FLAG_ZERO]  = zero;
        f[FLAG_CARRY] = carry;
        return f;
    endfunction

endpackage

// File: rtl/alu_result_uart_tx_core.sv
// Byte serialiser: start, 8 data bits LSB first, optional parity, stop.
// UART_PARITY_EN adds an even-parity bit after the data bits.
module uart_tx_core
    import alu_result_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic       clock,
    input  logic       i_reset,
    input  logic       i_byte_valid,
    input  logic [7:0] i_byte,
    output logic       o_byte_done,
    output logic       o_tx
);

    localparam int CBW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CBW-1:0] BAUD_LAST = CBW'(CLKS_PER_BIT - 1);

    logic [2:0]     r_state;
    logic [CBW-1:0] r_baud;
    logic [2:0]     r_bit;
    logic [7:0]     r_shift;
    logic           w_tick;
`ifdef UART_PARITY_EN
    logic           r_par;
`endif

    assign w_tick      = (r_baud == BAUD_LAST);
    assign o_byte_done = (r_state == ST_STOP) && w_tick;

    // Baud counter: free-runs per bit while a frame is on the line
    always_ff @(posedge clock) begin
        if (!i_reset) begin
            r_baud <= '0;
        end else if (r_state == ST_IDLE) begin
            r_baud <= '0;
        end else begin
            r_baud <= w_tick ? '0 : r_baud + 1'b1;
        end
    end

    // Frame sequencer; a stop bit may chain straight into the next start
    always_ff @(posedge clock) begin
        if (!i_reset) begin
            r_state <= ST_IDLE;
            o_tx    <= 1'b1;
            r_bit   <= '0;
            r_shift <= '0;
`ifdef UART_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    o_tx <= 1'b1;
                    if (i_byte_valid) begin
                        r_state <= ST_START;
                        o_tx    <= 1'b0;
                        r_shift <= i_byte;
`ifdef UART_PARITY_EN
                        r_par   <= ^i_byte;
`endif
                    end
                end
                ST_START: begin
                    if (w_tick) begin
                        r_state <= ST_DATA;
                        o_tx    <= r_shift[0];
                        r_bit   <= '0;
                    end
                end
                ST_DATA: begin
                    if (w_tick) begin
                        r_shift <= r_shift >> 1;
                        r_bit   <= r_bit + 3'd1;
                        if (r_bit == 3'd7) begin
`ifdef UART_PARITY_EN
                            r_state <= ST_PARITY;
                            o_tx    <= r_par;
`else
                            r_state <= ST_STOP;
                            o_tx    <= 1'b1;
`endif
                        end else begin
                            o_tx <= r_shift[1];
                        end
                    end
                end
`ifdef UART_PARITY_EN
                ST_PARITY: begin
                    if (w_tick) begin
                        r_state <= ST_STOP;
                        o_tx    <= 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (w_tick) begin
                        if (i_byte_valid) begin
                            r_state <= ST_START;
                            o_tx    <= 1'b0;
                            r_shift <= i_byte;
`ifdef UART_PARITY_EN
                            r_par   <= ^i_byte;
`endif
                        end else begin
                            r_state <= ST_IDLE;
                            o_tx    <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    o_tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/alu_result_uart_tx.sv
// Sends one ALU result (LSB byte first) plus a flags byte over UART.
// UART_PARITY_EN selects 8E1 framing in the serialiser (default 8N1).
module alu_result_uart_tx
    import alu_result_uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic                  clock,
    input  logic                  i_reset,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_result,
    input  logic                  i_carry,
    output logic                  o_ready,
    output logic                  o_tx,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int NBYTES = (DATA_WIDTH + 7) / 8;
    localparam int IDXW   = $clog2(NBYTES + 1);
    localparam int FW     = (NBYTES + 1) * 8;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NBYTES);

    logic [2:0]          r_state;
    logic [IDXW-1:0]     r_idx;
    logic [NBYTES*8-1:0] r_shift;
    logic [FW-1:0]       w_frame;
    logic                w_accept;
    logic                w_byte_valid;
    logic [7:0]          w_byte;
    logic                w_byte_done;

    // Padded result with the flags byte on top, built from live inputs
    always_comb begin
        w_frame = '0;
        w_frame[DATA_WIDTH-1:0] = i_result;
        w_frame[FW-1 -: 8] = flag_byte(i_result[DATA_WIDTH-1],
                                       i_result == '0,
                                       i_carry);
    end

    assign w_accept     = i_valid & o_ready;
    assign w_byte_valid = w_accept |
                          ((r_state == ST_DATA) && (r_idx != IDX_LAST));
    assign w_byte       = w_accept ? w_frame[7:0] : r_shift[7:0];

    uart_tx_core #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_core (
        .clock        (clock),
        .i_reset      (i_reset),
        .i_byte_valid (w_byte_valid),
        .i_byte       (w_byte),
        .o_byte_done  (w_byte_done),
        .o_tx         (o_tx)
    );

    // Result-level handshake; ST_DATA spans the whole multi-byte send
    always_ff @(posedge clock) begin
        if (!i_reset) begin
            r_state <= ST_IDLE;
            o_ready <= 1'b1;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
            r_idx   <= '0;
            r_shift <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= ST_DATA;
                        o_ready <= 1'b0;
                        o_busy  <= 1'b1;
                        r_idx   <= '0;
                        r_shift <= w_frame[FW-1:8];
                    end
                end
                ST_DATA: begin
                    if (w_byte_done) begin
                        if (r_idx == IDX_LAST) begin
                            r_state <= ST_DONE;
                            o_busy  <= 1'b0;
                            o_done  <= 1'b1;
                            r_idx   <= '0;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_shift <= r_shift >> 8;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    o_done  <= 1'b0;
                    o_ready <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                    o_ready <= 1'b1;
                    o_busy  <= 1'b0;
                    o_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_result_uart_tx.sv
// Directed bench for alu_result_uart_tx (CLKS_PER_BIT=4, DATA_WIDTH=8).
// Define UART_PARITY_EN to run the 8E1 variant and its parity test.
module tb_alu_result_uart_tx;

    localparam int CPB = 4;
    localparam int DW  = 8;
`ifdef UART_PARITY_EN
    localparam int BPF = 11;
`else
    localparam int BPF = 10;
`endif
    localparam int TOT = 2 * BPF * CPB;

    logic          clock = 1'b0;
    logic          i_reset = 1'b0;
    logic          i_valid = 1'b0;
    logic [DW-1:0] i_result = '0;
    logic          i_carry = 1'b0;
    logic          o_ready;
    logic          o_tx;
    logic          o_busy;
    logic          o_done;

    int   checks = 0;
    int   errors = 0;
    logic line_q  [0:255];
    logic ready_q [0:255];
    logic busy_q  [0:255];
    int   done_cyc;
    int   done_cnt;

    always #5 clock = ~clock;

    alu_result_uart_tx #(
        .DATA_WIDTH   (DW),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clock    (clock),
        .i_reset  (i_reset),
        .i_valid  (i_valid),
        .i_result (i_result),
        .i_carry  (i_carry),
        .o_ready  (o_ready),
        .o_tx     (o_tx),
        .o_busy   (o_busy),
        .o_done   (o_done)
    );

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Accept in the current cycle (T), then record cycles T+1..T+ncyc
    task automatic xfer(input logic [7:0] r, input logic c, input int ncyc,
                        input int pulse_at, input int rst_at,
                        input logic hold);
        i_result = r;
        i_carry  = c;
        i_valid  = 1'b1;
        check("accept_ready", 32'(o_ready), 32'd1);
        tick;
        done_cyc = -1;
        done_cnt = 0;
        for (int k = 1; k <= ncyc; k++) begin
            line_q[k]  = o_tx;
            ready_q[k] = o_ready;
            busy_q[k]  = o_busy;
            if (o_done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = k;
            end
            i_valid = hold | (k == pulse_at);
            i_reset = (k == rst_at) ? 1'b0 : 1'b1;
            if (!hold) begin
                i_result = 8'($urandom);
                i_carry  = 1'($urandom);
            end
            tick;
        end
        i_valid = 1'b0;
    endtask

    task automatic chk_frame(input string tag, input int f,
                             input logic [7:0] exp);
        int b0;
        logic [7:0] d;
        b0 = 1 + f * BPF * CPB;
        check({tag, "_start"}, 32'(line_q[b0 + 2]), 32'd0);
        for (int i = 0; i < 8; i++) d[i] = line_q[b0 + (1 + i) * CPB + 2];
        check({tag, "_data"}, 32'(d), 32'(exp));
        check({tag, "_stop"}, 32'(line_q[b0 + (BPF - 1) * CPB + 2]), 32'd1);
    endtask

    initial begin
        int lows;
        int n;

        // 1: reset held 3 cycles with i_valid high
        i_reset = 1'b0;
        i_valid = 1'b1;
        tick; tick; tick;
        check("rst_tx",    32'(o_tx),    32'd1);
        check("rst_ready", 32'(o_ready), 32'd1);
        check("rst_busy",  32'(o_busy),  32'd0);
        check("rst_done",  32'(o_done),  32'd0);
        i_valid = 1'b0;
        i_reset = 1'b1;
        tick;
        check("post_rst_tx",   32'(o_tx),   32'd1);
        check("post_rst_busy", 32'(o_busy), 32'd0);

        // 2: 0x7F, carry 0 -> 7F, 00
        xfer(8'h7F, 1'b0, TOT + 1, -1, -1, 1'b0);
        for (int k = 1; k <= 4; k++)
            check($sformatf("t2_start_c%0d", k), 32'(line_q[k]), 32'd0);
        check("t2_bit0_first", 32'(line_q[5]), 32'd1);
        chk_frame("t2_b0", 0, 8'h7F);
        chk_frame("t2_fl", 1, 8'h00);
        check("t2_busy_t1",  32'(busy_q[1]), 32'd1);
        check("t2_done_cyc", 32'(done_cyc), 32'(TOT + 1));
        check("t2_done_cnt", 32'(done_cnt), 32'd1);
        check("t2_ready_back", 32'(o_ready), 32'd1);

        // 3: 0x00, carry 1 -> 00, 03; extra valid at T+40 ignored
        xfer(8'h00, 1'b1, TOT + 20, 40, -1, 1'b0);
        chk_frame("t3_b0", 0, 8'h00);
        chk_frame("t3_fl", 1, 8'h03);
        check("t3_done_cyc", 32'(done_cyc), 32'(TOT + 1));
        check("t3_done_cnt", 32'(done_cnt), 32'd1);
        lows = 0;
        for (int k = TOT + 1; k <= TOT + 20; k++) if (!line_q[k]) lows++;
        check("t3_no_third_frame", 32'(lows), 32'd0);

        // 4: 0x80, carry 1; reset at T+30, new accept at T+35
        xfer(8'h80, 1'b1, 34, -1, 30, 1'b0);
        check("t4_start", 32'(line_q[1]), 32'd0);
        for (int k = 31; k <= 34; k++)
            check($sformatf("t4_idle_c%0d", k), 32'(line_q[k]), 32'd1);
        check("t4_ready31", 32'(ready_q[31]), 32'd1);
        check("t4_busy31",  32'(busy_q[31]),  32'd0);
        check("t4_no_done", 32'(done_cnt),    32'd0);
        xfer(8'hA5, 1'b0, TOT + 1, -1, -1, 1'b0);
        chk_frame("t4_b0", 0, 8'hA5);
        chk_frame("t4_fl", 1, 8'h04);
        check("t4_done_cyc", 32'(done_cyc), 32'(TOT + 1));

        // 5: i_valid held high -> back-to-back accept after o_done
        xfer(8'h80, 1'b1, TOT + 8, -1, -1, 1'b1);
        chk_frame("t5_b0", 0, 8'h80);
        chk_frame("t5_fl", 1, 8'h05);
        check("t5_done_cyc",  32'(done_cyc),          32'(TOT + 1));
        check("t5_ready_acc", 32'(ready_q[TOT + 2]),  32'd1);
        check("t5_idle_acc",  32'(line_q[TOT + 2]),   32'd1);
        check("t5_start2",    32'(line_q[TOT + 3]),   32'd0);
        check("t5_busy2",     32'(busy_q[TOT + 3]),   32'd1);
        n = 0;
        while (!o_done && n < 300) begin
            tick;
            n++;
        end
        check("t5_done2_seen", 32'(o_done), 32'd1);
        tick;
        tick;
        check("t5_ready2", 32'(o_ready), 32'd1);

`ifdef UART_PARITY_EN
        // 6: 0x07 -> parity 1, flags 00 -> parity 0
        xfer(8'h07, 1'b0, TOT + 1, -1, -1, 1'b0);
        chk_frame("t6_b0", 0, 8'h07);
        chk_frame("t6_fl", 1, 8'h00);
        check("t6_par0", 32'(line_q[1 + 9 * CPB + 2]), 32'd1);
        check("t6_par1", 32'(line_q[1 + BPF * CPB + 9 * CPB + 2]), 32'd0);
        check("t6_done_cyc", 32'(done_cyc), 32'd89);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
